id_ex_skid: RTL

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid.sv | 101 ++++++++++
 1 files changed

// File: rtl/id_ex_skid.sv
// rtl/id_ex_skid.sv - ID/EX pipeline register with a one-entry skid buffer
module id_ex_skid #(
    parameter int FUNCT_W = 6,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [FUNCT_W-1:0] id_funct,
    input  logic               id_logic_en,
    input  logic [DATA_W-1:0]  id_operand_1,
    input  logic [DATA_W-1:0]  id_operand_2,
    input  logic [4:0]         id_waddr,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic               ex_logic_en,
    output logic [DATA_W-1:0]  ex_operand_1,
    output logic [DATA_W-1:0]  ex_operand_2,
    output logic [4:0]         ex_waddr,
    output logic [1:0]         occupancy
);

    localparam int PW = FUNCT_W + 1 + 2 * DATA_W + 5;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl;
    logic [PW-1:0] skid_pl;
    logic [PW-1:0] main_pl_nx;
    logic [PW-1:0] skid_pl_nx;
    logic          main_valid;
    logic          skid_valid;
    logic          main_valid_nx;
    logic          skid_valid_nx;
    logic [1:0]    occ_q;
    logic [1:0]    occ_nx;
    logic          in_xfer;
    logic          out_xfer;

    assign in_pl = {id_funct, id_logic_en, id_operand_1, id_operand_2, id_waddr};
    assign {ex_funct, ex_logic_en, ex_operand_1, ex_operand_2, ex_waddr} = main_pl;

    // Ready depends only on the skid flop, so ex_ready never reaches id_ready.
    assign id_ready  = ~skid_valid;
    assign ex_valid  = main_valid;
    assign occupancy = occ_q;

    assign in_xfer  = id_valid & id_ready;
    assign out_xfer = main_valid & ex_ready;

    // Next-state selection: flush wins, then drain/refill of main, then skid fill.
    always_comb begin
        main_pl_nx    = main_pl;
        skid_pl_nx    = skid_pl;
        main_valid_nx = main_valid;
        skid_valid_nx = skid_valid;
        if (flush) begin
            main_valid_nx = 1'b0;
            skid_valid_nx = 1'b0;
        end else if (out_xfer) begin
            if (skid_valid) begin
                // id_ready is low here, so no input can arrive this cycle.
                main_pl_nx    = skid_pl;
                skid_valid_nx = 1'b0;
            end else if (in_xfer) begin
                main_pl_nx = in_pl;
            end else begin
                main_valid_nx = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid) begin
                main_pl_nx    = in_pl;
                main_valid_nx = 1'b1;
            end else begin
                skid_pl_nx    = in_pl;
                skid_valid_nx = 1'b1;
            end
        end
        occ_nx = {1'b0, main_valid_nx} + {1'b0, skid_valid_nx};
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_pl    <= '0;
            skid_pl    <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            main_pl    <= main_pl_nx;
            skid_pl    <= skid_pl_nx;
            main_valid <= main_valid_nx;
            skid_valid <= skid_valid_nx;
            occ_q      <= occ_nx;
        end
    end

endmodule
